// File: rtl/alu_logic_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_logic_pipe                                                  |
// | Brief    : LEGv8 bitwise-op unit with a bubble-collapsing valid/ready pipe |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_logic_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    op,
  input  logic [DATA_WIDTH-1:0]         A,
  input  logic [DATA_WIDTH-1:0]         B,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         result,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          zero,
  output logic                          negative,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int         c_occ_w  = $clog2(STAGES + 1);
  localparam logic [2:0] c_op_and = 3'b000;
  localparam logic [2:0] c_op_orr = 3'b001;
  localparam logic [2:0] c_op_eor = 3'b010;
  localparam logic [2:0] c_op_bic = 3'b011;
  localparam logic [2:0] c_op_orn = 3'b100;
  localparam logic [2:0] c_op_eon = 3'b101;
  localparam logic [2:0] c_op_mov = 3'b110;

  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_zero_in;
  logic                  w_neg_in;
  logic [STAGES-1:0]     w_valid;
  logic [STAGES-1:0]     w_adv;

  always_comb begin
    w_result = ~B;
    case (op)
      c_op_and: w_result = A & B;
      c_op_orr: w_result = A | B;
      c_op_eor: w_result = A ^ B;
      c_op_bic: w_result = A & ~B;
      c_op_orn: w_result = A | ~B;
      c_op_eon: w_result = A ^ ~B;
      c_op_mov: w_result = A;
      default:  w_result = ~B;
    endcase
  end

  assign w_zero_in = (w_result == '0);
  assign w_neg_in  = w_result[DATA_WIDTH-1];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic                  r_valid;
      logic [DATA_WIDTH-1:0] r_data;
      logic [TAG_WIDTH-1:0]  r_tag;
      logic                  r_zero;
      logic                  r_neg;
      logic                  w_src_valid;
      logic [DATA_WIDTH-1:0] w_src_data;
      logic [TAG_WIDTH-1:0]  w_src_tag;
      logic                  w_src_zero;
      logic                  w_src_neg;

      // A stage may load whenever any stage from here to the output is empty,
      // which is what lets bubbles collapse under a stalled consumer.
      assign w_adv[k]   = out_ready | ~(&w_valid[STAGES-1:k]);
      assign w_valid[k] = r_valid;

      if (k == 0) begin : g_src
        assign w_src_valid = in_valid;
        assign w_src_data  = w_result;
        assign w_src_tag   = in_tag;
        assign w_src_zero  = w_zero_in;
        assign w_src_neg   = w_neg_in;
      end else begin : g_src
        assign w_src_valid = g_stage[k-1].r_valid;
        assign w_src_data  = g_stage[k-1].r_data;
        assign w_src_tag   = g_stage[k-1].r_tag;
        assign w_src_zero  = g_stage[k-1].r_zero;
        assign w_src_neg   = g_stage[k-1].r_neg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_tag   <= '0;
          r_zero  <= 1'b0;
          r_neg   <= 1'b0;
        end else if (w_adv[k]) begin
          r_valid <= w_src_valid;
          r_data  <= w_src_data;
          r_tag   <= w_src_tag;
          r_zero  <= w_src_zero;
          r_neg   <= w_src_neg;
        end
      end
    end
  endgenerate

  assign in_ready  = w_adv[0];
  assign out_valid = g_stage[STAGES-1].r_valid;
  assign result    = g_stage[STAGES-1].r_data;
  assign out_tag   = g_stage[STAGES-1].r_tag;
  assign zero      = g_stage[STAGES-1].r_zero;
  assign negative  = g_stage[STAGES-1].r_neg;
  assign occupancy = c_occ_w'($countones(w_valid));

endmodule
`default_nettype wire

// File: tb/tb_alu_logic_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_logic_pipe                                               |
// | Brief    : bench for alu_logic_pipe, default and minimal parameter sets    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_logic_pipe;

  localparam int S0 = 2;
  localparam int W0 = 64;
  localparam int S1 = 1;
  localparam int W1 = 8;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          age;
  } ent_t;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
    logic        n;
  } vec_t;

  logic clk;
  int   nvec;
  int   nfail;
  bit   done1;

  logic        rst_n, in_valid0, in_ready0, out_valid0, out_ready0, zero0, neg0;
  logic [2:0]  op0;
  logic [63:0] a0, b0, res0;
  logic [4:0]  tag0, otag0;
  logic [1:0]  occ0;

  logic        rst1_n, in_valid1, in_ready1, out_valid1, out_ready1, zero1, neg1;
  logic [2:0]  op1;
  logic [7:0]  a1, b1, res1;
  logic [0:0]  tag1, otag1;
  logic [0:0]  occ1;

  ent_t q0[$];
  ent_t q1[$];

  alu_logic_pipe #(.DATA_WIDTH(W0), .STAGES(S0), .TAG_WIDTH(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .op(op0), .A(a0), .B(b0), .in_tag(tag0), .out_valid(out_valid0),
    .out_ready(out_ready0), .result(res0), .out_tag(otag0), .zero(zero0),
    .negative(neg0), .occupancy(occ0)
  );

  alu_logic_pipe #(.DATA_WIDTH(W1), .STAGES(S1), .TAG_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op1), .A(a1), .B(b1), .in_tag(tag1), .out_valid(out_valid1),
    .out_ready(out_ready1), .result(res1), .out_tag(otag1), .zero(zero1),
    .negative(neg1), .occupancy(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] a,
                                         input logic [63:0] b, input int w);
    logic [63:0] r;
    logic [63:0] m;
    case (o)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = a & ~b;
      3'd4:    r = a | ~b;
      3'd5:    r = a ^ ~b;
      3'd6:    r = a;
      default: r = ~b;
    endcase
    m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return r & m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: a FIFO of in-flight ops; the head reaches the output once it
  // has been inside for STAGES-1 edges, because nothing ahead can hold it back.
  always @(negedge clk) begin : m0
    bit   ir, ov;
    ent_t e;
    if (!rst_n) begin
      q0.delete();
      chk("rst0 out_valid", 64'(out_valid0), 64'd0);
      chk("rst0 occupancy", 64'(occ0), 64'd0);
      chk("rst0 in_ready", 64'(in_ready0), 64'd1);
      chk("rst0 result", res0, 64'd0);
      chk("rst0 out_tag", 64'(otag0), 64'd0);
      chk("rst0 flags", 64'({zero0, neg0}), 64'd0);
    end else begin
      ir = (q0.size() < S0) || out_ready0;
      ov = (q0.size() > 0) && (q0[0].age >= S0 - 1);
      if (ov && out_ready0) void'(q0.pop_front());
      foreach (q0[k]) q0[k].age = q0[k].age + 1;
      if (in_valid0 && ir) begin
        e.res = ref_op(op0, a0, b0, W0);
        e.tag = tag0;
        e.age = 0;
        q0.push_back(e);
      end
      ov = (q0.size() > 0) && (q0[0].age >= S0 - 1);
      chk("m0 out_valid", 64'(out_valid0), 64'(ov));
      chk("m0 occupancy", 64'(occ0), 64'(q0.size()));
      chk("m0 in_ready", 64'(in_ready0), 64'((q0.size() < S0) || out_ready0));
      if (ov) begin
        chk("m0 result", res0, q0[0].res);
        chk("m0 out_tag", 64'(otag0), 64'(q0[0].tag));
        chk("m0 zero", 64'(zero0), 64'(q0[0].res == 64'd0));
        chk("m0 negative", 64'(neg0), 64'(q0[0].res[W0-1]));
      end
    end
  end

  always @(negedge clk) begin : m1
    bit   ir, ov;
    ent_t e;
    if (!rst1_n) begin
      q1.delete();
      chk("rst1 out_valid", 64'(out_valid1), 64'd0);
      chk("rst1 in_ready", 64'(in_ready1), 64'd1);
    end else begin
      ir = (q1.size() < S1) || out_ready1;
      ov = (q1.size() > 0) && (q1[0].age >= S1 - 1);
      if (ov && out_ready1) void'(q1.pop_front());
      foreach (q1[k]) q1[k].age = q1[k].age + 1;
      if (in_valid1 && ir) begin
        e.res = ref_op(op1, 64'(a1), 64'(b1), W1);
        e.tag = 5'(tag1);
        e.age = 0;
        q1.push_back(e);
      end
      ov = (q1.size() > 0) && (q1[0].age >= S1 - 1);
      chk("m1 out_valid", 64'(out_valid1), 64'(ov));
      chk("m1 occupancy", 64'(occ1), 64'(q1.size()));
      chk("m1 in_ready", 64'(in_ready1), 64'((q1.size() < S1) || out_ready1));
      if (ov) begin
        chk("m1 result", 64'(res1), q1[0].res);
        chk("m1 out_tag", 64'(otag1), 64'(q1[0].tag));
        chk("m1 zero", 64'(zero1), 64'(q1[0].res == 64'd0));
        chk("m1 negative", 64'(neg1), 64'(q1[0].res[W1-1]));
      end
    end
  end

  // Issue one op into an empty, unstalled default pipe and check two-cycle latency.
  task automatic issue_check(input string name, input logic [2:0] o, input logic [63:0] a,
                             input logic [63:0] b, input logic [4:0] t,
                             input logic [63:0] er, input logic ez, input logic en);
    out_ready0 = 1'b1;
    in_valid0  = 1'b1;
    op0 = o; a0 = a; b0 = b; tag0 = t;
    tick();
    chk({name, " early valid"}, 64'(out_valid0), 64'd0);
    in_valid0 = 1'b0;
    tick();
    chk({name, " valid"}, 64'(out_valid0), 64'd1);
    chk({name, " result"}, res0, er);
    chk({name, " tag"}, 64'(otag0), 64'(t));
    chk({name, " zero"}, 64'(zero0), 64'(ez));
    chk({name, " negative"}, 64'(neg0), 64'(en));
  endtask

  initial begin : main
    vec_t        tv[9];
    logic [63:0] e1;
    logic [4:0]  t1;
    nvec = 0; nfail = 0;
    rst_n = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1;
    op0 = '0; a0 = '0; b0 = '0; tag0 = '0;

    tv[0] = '{3'b001, 64'h00F0_0000_0000_000F, 64'h0F00_0000_0000_00F0, 64'h0FF0_0000_0000_00FF, 1'b0, 1'b0};
    tv[1] = '{3'b010, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'h0, 1'b1, 1'b0};
    tv[2] = '{3'b111, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    tv[3] = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0};
    tv[4] = '{3'b110, 64'h0, 64'h5555, 64'h0, 1'b1, 1'b0};
    tv[5] = '{3'b000, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b1};
    tv[6] = '{3'b100, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b0, 1'b0};
    tv[7] = '{3'b101, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b1, 1'b0};
    tv[8] = '{3'b110, 64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      issue_check("table", tv[i].op, tv[i].a, tv[i].b, 5'(i + 3), tv[i].res, tv[i].z, tv[i].n);

    // walking ones, one op per cycle, all eight ops
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 64; i++) begin
        in_valid0 = 1'b1;
        op0  = 3'(o);
        a0   = 64'd1 << i;
        b0   = 64'd1 << ((i + o) % 64);
        tag0 = 5'(i);
        tick();
      end
    end
    in_valid0 = 1'b0;
    repeat (3) tick();

    // full stall: two accepted, third held off, then drain with same-cycle accept
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; op0 = 3'd2; a0 = 64'hCAFE_0000_1234_5678; b0 = 64'h0000_FFFF_0000_FFFF; tag0 = 5'd1;
    e1 = ref_op(3'd2, a0, b0, 64);
    t1 = 5'd1;
    tick();
    op0 = 3'd4; a0 = 64'h1; b0 = 64'h2; tag0 = 5'd2;
    tick();
    op0 = 3'd7; a0 = 64'h3; b0 = 64'hFF; tag0 = 5'd3;
    chk("stall occupancy", 64'(occ0), 64'd2);
    chk("stall in_ready", 64'(in_ready0), 64'd0);
    repeat (10) tick();
    chk("stall result", res0, e1);
    chk("stall tag", 64'(otag0), 64'(t1));
    chk("stall valid", 64'(out_valid0), 64'd1);
    out_ready0 = 1'b1;
    #1;
    chk("drain in_ready", 64'(in_ready0), 64'd1);
    tick();
    chk("drain occupancy", 64'(occ0), 64'd2);
    in_valid0 = 1'b0;
    repeat (3) tick();

    // asynchronous reset with two ops in flight
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; op0 = 3'd1; a0 = 64'hF; b0 = 64'hF0; tag0 = 5'd7;
    tick();
    op0 = 3'd7; b0 = 64'h0; tag0 = 5'd9;
    tick();
    in_valid0 = 1'b0;
    chk("prerst occupancy", 64'(occ0), 64'd2);
    chk("prerst valid", 64'(out_valid0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst valid", 64'(out_valid0), 64'd0);
    chk("midrst occupancy", 64'(occ0), 64'd0);
    chk("midrst in_ready", 64'(in_ready0), 64'd1);
    chk("midrst result", res0, 64'd0);
    chk("midrst tag", 64'(otag0), 64'd0);
    chk("midrst flags", 64'({zero0, neg0}), 64'd0);
    tick();
    rst_n = 1'b1;
    issue_check("postrst", 3'd5, 64'h00FF, 64'hFF00, 5'd17, 64'hFFFF_FFFF_FFFF_0000, 1'b0, 1'b1);

    // randomized traffic against the reference FIFO
    for (int c = 0; c < 1500; c++) begin
      in_valid0  = ($urandom % 4) != 0;
      out_ready0 = ($urandom % 3) != 0;
      op0  = 3'($urandom);
      a0   = {$urandom, $urandom};
      b0   = {$urandom, $urandom};
      tag0 = 5'($urandom);
      tick();
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    repeat (4) tick();
    chk("drain0 empty", 64'(q0.size()), 64'd0);

    for (int c = 0; c < 5000 && !done1; c++) tick();
    chk("dut1 done", 64'(done1), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin : drv1
    done1 = 1'b0;
    rst1_n = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
    op1 = '0; a1 = '0; b1 = '0; tag1 = '0;
    repeat (3) @(negedge clk);
    #1;
    rst1_n = 1'b1;
    in_valid1 = 1'b1; op1 = 3'd3; a1 = 8'hF0; b1 = 8'h30; tag1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("dut1 lat valid", 64'(out_valid1), 64'd1);
    chk("dut1 lat result", 64'(res1), 64'hC0);
    chk("dut1 lat negative", 64'(neg1), 64'd1);
    for (int c = 0; c < 1500; c++) begin
      in_valid1  = $urandom % 2 == 1;
      out_ready1 = ($urandom % 4) != 0;
      op1  = 3'($urandom);
      a1   = 8'($urandom);
      b1   = 8'($urandom);
      tag1 = 1'($urandom);
      tick();
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    repeat (3) tick();
    chk("drain1 empty", 64'(q1.size()), 64'd0);
    done1 = 1'b1;
  end

  initial begin : watchdog
    #1000000;
    nfail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
